// File: rtl/ofifo_drain.sv
// ofifo_drain: pops num_out psum vectors from the OFIFO into psum SRAM at base_addr+index, optional RMW accumulate and ReLU; ODRAIN_SAT_EN makes the accumulate saturate.
// Latency 4 cycles/vector (5 accumulating) with ofifo_valid high; stalls in WAIT while ofifo_valid is low, and a pop is never issued without it.
module ofifo_drain #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11,
  parameter int num_out = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     acc_mode,
  input  logic                     relu_en,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_data,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_addr,
  output logic [col*psum_bw-1:0]   sram_d,
  input  logic [col*psum_bw-1:0]   sram_q,
  output logic                     busy,
  output logic                     done
);

  localparam int VW = col * psum_bw;
  localparam logic [addr_bw-1:0] LAST = addr_bw'(num_out - 1);

  typedef enum logic [2:0] {IDLE, WAIT, POP, LATCH, RDACC, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [addr_bw-1:0] cnt_q, cnt_d;
  logic [VW-1:0]      data_q, data_d;
  logic               acc_q, acc_d;
  logic               relu_q, relu_d;
  logic [addr_bw-1:0] base_q, base_d;
  logic [addr_bw-1:0] addr_q, addr_d;
  logic [VW-1:0]      wdat_q, wdat_d;

  function automatic logic [psum_bw-1:0] lane_add(input logic [psum_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b);
    logic [psum_bw-1:0] s;
    s = a + b;
`ifdef ODRAIN_SAT_EN
    // Overflow only when both operands share a sign the result lost.
    if ((a[psum_bw-1] == b[psum_bw-1]) && (s[psum_bw-1] != a[psum_bw-1]))
      s = a[psum_bw-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
`endif
    return s;
  endfunction

  function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] v, input logic en);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < col; i++) begin
      if (en && v[i*psum_bw + psum_bw-1]) r[i*psum_bw +: psum_bw] = '0;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    acc_d   = acc_q;
    relu_d  = relu_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = acc_mode;
          relu_d  = relu_en;
          base_d  = base_addr;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: if (ofifo_valid) state_d = POP;
      POP: begin
        state_d = LATCH;
        // The accumulate read is issued in LATCH, so its address must be ready then.
        if (acc_q) addr_d = base_q + cnt_q;
      end
      LATCH: begin
        data_d = ofifo_data;
        if (acc_q) begin
          state_d = RDACC;
        end else begin
          state_d = WRITE;
          addr_d  = base_q + cnt_q;
          wdat_d  = relu_vec(ofifo_data, relu_q);
        end
      end
      RDACC: begin
        for (int i = 0; i < col; i++)
          data_d[i*psum_bw +: psum_bw] = lane_add(data_q[i*psum_bw +: psum_bw],
                                                  sram_q[i*psum_bw +: psum_bw]);
        addr_d  = base_q + cnt_q;
        wdat_d  = relu_vec(data_d, relu_q);
        state_d = WRITE;
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      acc_q   <= 1'b0;
      relu_q  <= 1'b0;
      base_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      relu_q  <= relu_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
    end
  end

  assign ofifo_rd  = (state_q == POP);
  assign sram_cen  = !(((state_q == LATCH) && acc_q) || (state_q == WRITE));
  assign sram_wen  = (state_q != WRITE);
  assign sram_addr = addr_q;
  assign sram_d    = wdat_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain with an OFIFO model, a synchronous SRAM model and a write log.
module tb_ofifo_drain;
  localparam int COL = 8, PBW = 16, ABW = 11, NOUT = 4, W = COL * PBW;

  logic           clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic           acc_mode = 1'b0, relu_en = 1'b0, ofifo_valid = 1'b0;
  logic [ABW-1:0] base_addr = '0;
  logic [W-1:0]   ofifo_data, sram_q;
  logic           ofifo_rd, sram_cen, sram_wen, busy, done;
  logic [ABW-1:0] sram_addr;
  logic [W-1:0]   sram_d;

  int n_chk = 0, n_fail = 0;
  int cyc, pop_cnt;
  logic [W-1:0] mem [2**ABW];
  logic [W-1:0] fifo_q [$];
  int           wr_addr [$], wr_cyc [$], rd_addr [$], rd_cyc [$];
  logic [W-1:0] wr_dat [$];
  logic [W-1:0] exp_d [NOUT];

  ofifo_drain #(.col(COL), .psum_bw(PBW), .addr_bw(ABW), .num_out(NOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode), .relu_en(relu_en),
    .base_addr(base_addr), .ofifo_valid(ofifo_valid), .ofifo_data(ofifo_data),
    .ofifo_rd(ofifo_rd), .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_d(sram_d), .sram_q(sram_q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      ofifo_data <= '0;
      sram_q     <= '0;
    end else begin
      if (ofifo_rd) begin
        pop_cnt <= pop_cnt + 1;
        if (fifo_q.size() > 0) ofifo_data <= fifo_q.pop_front();
      end
      if (!sram_cen && sram_wen) begin
        sram_q <= mem[sram_addr];
        rd_addr.push_back(int'(sram_addr));
        rd_cyc.push_back(cyc);
      end
      if (!sram_cen && !sram_wen) begin
        mem[sram_addr] = sram_d;
        wr_addr.push_back(int'(sram_addr));
        wr_dat.push_back(sram_d);
        wr_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int b);
    logic [W-1:0] v;
    for (int j = 0; j < COL; j++) v[j*PBW +: PBW] = 16'(b + j);
    return v;
  endfunction

  function automatic logic [W-1:0] v2(input int l0, input int l1);
    logic [W-1:0] v;
    v = '0;
    v[0 +: PBW]   = 16'(l0);
    v[PBW +: PBW] = 16'(l1);
    return v;
  endfunction

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    fifo_q.delete();
    fifo_q.push_back(a); fifo_q.push_back(b); fifo_q.push_back(c); fifo_q.push_back(d);
  endtask

  task automatic start_drain(input int b, input logic acc, input logic relu, output int c0);
    wr_addr.delete(); wr_dat.delete(); wr_cyc.delete(); rd_addr.delete(); rd_cyc.delete();
    @(negedge clk);
    base_addr = ABW'(b); acc_mode = acc; relu_en = relu; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input int c0, input int exp_cyc);
    int n = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, done, 1);
    if (exp_cyc >= 0) chk({tag, "_cycles"}, cyc - c0, exp_cyc);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {busy, done}, 2'b00);
  endtask

  task automatic check_writes(input string tag, input int b);
    chk({tag, "_nwr"}, wr_addr.size(), NOUT);
    for (int k = 0; k < NOUT && k < wr_addr.size(); k++) begin
      chk({tag, "_addr"}, wr_addr[k], (b + k) % (2**ABW));
      chk({tag, "_data"}, wr_dat[k], exp_d[k]);
    end
  endtask

  initial begin
    int c0, p0, bad_rd, bad_busy;
    for (int a = 0; a < 2**ABW; a++) mem[a] = '0;
    #12;
    chk("rst_ofifo_rd", ofifo_rd, 0);
    chk("rst_cen_wen", {sram_cen, sram_wen}, 2'b11);
    chk("rst_addr", sram_addr, 0);
    chk("rst_d", sram_d, 0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    @(negedge clk); reset = 1'b1;
    ofifo_valid = 1'b1;

    // Overwrite drain
    load(mk(0), mk(10), mk(20), mk(30));
    exp_d = '{mk(0), mk(10), mk(20), mk(30)};
    p0 = pop_cnt;
    start_drain('h010, 1'b0, 1'b0, c0);
    wait_done("ovw", c0, 16);
    check_writes("ovw", 'h010);
    chk("ovw_pops", pop_cnt - p0, NOUT);
    chk("ovw_no_reads", rd_addr.size(), 0);
    if (wr_cyc.size() > 1) chk("ovw_vec_period", wr_cyc[1] - wr_cyc[0], 4);

    // Accumulate drain
    mem['h020] = v2(100, 5);
    load(v2(-30, 7), mk(10), mk(20), mk(30));
    exp_d = '{v2(70, 12), mk(10), mk(20), mk(30)};
    start_drain('h020, 1'b1, 1'b0, c0);
    wait_done("acc", c0, 20);
    check_writes("acc", 'h020);
    chk("acc_nrd", rd_addr.size(), NOUT);
    if (rd_addr.size() > 0 && wr_cyc.size() > 1) begin
      chk("acc_rd_addr", rd_addr[0], 'h020);
      chk("acc_rd_to_wr", wr_cyc[0] - rd_cyc[0], 2);
      chk("acc_vec_period", wr_cyc[1] - wr_cyc[0], 5);
    end

    // ReLU, overwrite
    load(v2(-5, 9), mk(10), v2(-1, -32768), mk(30));
    exp_d = '{v2(0, 9), mk(10), v2(0, 0), mk(30)};
    start_drain('h030, 1'b0, 1'b1, c0);
    wait_done("relu_ovw", c0, 16);
    check_writes("relu_ovw", 'h030);

    // ReLU after wrap or saturation, accumulate
    mem['h040] = v2(32767, -2);
    load(v2(1, 1), mk(10), mk(20), mk(30));
`ifdef ODRAIN_SAT_EN
    exp_d = '{v2(32767, 0), mk(10), mk(20), mk(30)};
`else
    exp_d = '{v2(0, 0), mk(10), mk(20), mk(30)};
`endif
    start_drain('h040, 1'b1, 1'b1, c0);
    wait_done("relu_acc", c0, 20);
    check_writes("relu_acc", 'h040);

    // Stall before vector 2 and address wrap
    load(mk(0), mk(10), mk(20), mk(30));
    exp_d = '{mk(0), mk(10), mk(20), mk(30)};
    p0 = pop_cnt;
    start_drain('h7FE, 1'b0, 1'b0, c0);
    for (int i = 0; i < 50 && (pop_cnt - p0) < 2; i++) @(negedge clk);
    chk("stall_pops_before", pop_cnt - p0, 2);
    ofifo_valid = 1'b0;
    bad_rd = 0; bad_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (ofifo_rd) bad_rd++;
      if (!busy) bad_busy++;
    end
    chk("stall_no_rd", bad_rd, 0);
    chk("stall_busy_high", bad_busy, 0);
    chk("stall_pops_held", pop_cnt - p0, 2);
    ofifo_valid = 1'b1;
    wait_done("stall", c0, -1);
    check_writes("stall", 'h7FE);
    chk("stall_pops", pop_cnt - p0, NOUT);

    // Reset during RDACC
    load(mk(0), mk(10), mk(20), mk(30));
    start_drain('h050, 1'b1, 1'b0, c0);
    for (int i = 0; i < 50 && sram_cen; i++) @(negedge clk);
    chk("mid_latch_read", {sram_cen, sram_wen}, 2'b01);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_ofifo_rd", ofifo_rd, 0);
    chk("mid_rst_cen_wen", {sram_cen, sram_wen}, 2'b11);
    chk("mid_rst_addr", sram_addr, 0);
    chk("mid_rst_d", sram_d, 0);
    chk("mid_rst_busy_done", {busy, done}, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_write", wr_addr.size(), 0);
    @(negedge clk); reset = 1'b1;
    load(mk(100), mk(110), mk(120), mk(130));
    exp_d = '{mk(100), mk(110), mk(120), mk(130)};
    start_drain('h060, 1'b0, 1'b0, c0);
    wait_done("post_rst", c0, 16);
    check_writes("post_rst", 'h060);

    // start while busy
    load(mk(40), mk(50), mk(60), mk(70));
    exp_d = '{mk(40), mk(50), mk(60), mk(70)};
    start_drain('h070, 1'b0, 1'b0, c0);
    repeat (5) @(negedge clk);
    base_addr = ABW'('h100); acc_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", c0, 16);
    check_writes("busy_start", 'h070);
    chk("busy_start_no_reads", rd_addr.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start_no_restart", {busy, wr_addr.size() == NOUT}, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ofifo_drain.md
Name: ofifo_drain

Overview:
- Downstream neighbour of the corelet. Pops one col-wide psum vector at a time from the corelet OFIFO and writes it to the psum SRAM at base_addr+index.
- In accumulate mode it does a read-modify-write: the popped vector is added lane-wise to the vector already stored at that address, so multi-pass partial sums fold together.
- Optional ReLU is applied on the write. One tile of num_out vectors is drained per start pulse.

Parameters:
col, 8, number of psum lanes per vector
psum_bw, 16, signed width of each lane
addr_bw, 11, psum SRAM address width
num_out, 16, vectors drained per start (1..2^addr_bw)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  one-cycle pulse; begins a drain; ignored while busy
acc_mode  input  1  sampled at start; 1 = read-modify-write, 0 = overwrite
relu_en  input  1  sampled at start; 1 = clamp negative lanes to 0 on write
base_addr  input  addr_bw  sampled at start; SRAM address of vector 0
ofifo_valid  input  1  OFIFO holds at least one vector
ofifo_data  input  col*psum_bw  OFIFO read data, valid the cycle after ofifo_rd
ofifo_rd  output  1  OFIFO pop strobe
sram_cen  output  1  SRAM chip enable, active-low
sram_wen  output  1  SRAM write enable, active-low (1 = read)
sram_addr  output  addr_bw  SRAM address
sram_d  output  col*psum_bw  SRAM write data
sram_q  input  col*psum_bw  SRAM read data, valid the cycle after a read access
busy  output  1  high from the cycle after start until the DONE cycle
done  output  1  one-cycle pulse when the last vector is written

Behaviour:
- Reset (reset=0, async): state=IDLE, cnt=0, data_q=0. Outputs: ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0, busy=0, done=0. A reset mid-drain aborts the drain; no partial write completes after reset asserts.
- Outputs are Moore outputs decoded from registered state, cnt and data_q.
- FSM states: IDLE, WAIT, POP, LATCH, RDACC, WRITE, DONE.
- IDLE: on start, latch acc_mode, relu_en and base_addr; set cnt=0; go to WAIT.
- WAIT: stall while ofifo_valid=0; when ofifo_valid=1, go to POP.
- POP: ofifo_rd=1 for exactly one cycle; go to LATCH.
- LATCH: data_q <= ofifo_data. If acc_mode, drive sram_cen=0, sram_wen=1, sram_addr=base_addr+cnt, then go to RDACC; otherwise go to WRITE.
- RDACC: each lane i gets data_q[i] <= data_q[i] + sram_q[i] (signed, psum_bw result); go to WRITE.
- WRITE: sram_cen=0, sram_wen=0, sram_addr=base_addr+cnt, sram_d=data_q with per-lane ReLU if relu_en. If cnt==num_out-1, go to DONE; otherwise cnt++ and go to WAIT.
- DONE: done=1, busy still 1; go to IDLE.
- Latency per vector, ofifo_valid already high: 4 cycles in overwrite mode (WAIT, POP, LATCH, WRITE), 5 cycles in accumulate mode.
- Address is (base_addr+cnt) mod 2^addr_bw; it wraps silently past the top of SRAM.
- Addition wraps modulo 2^psum_bw unless the optional feature is enabled.
- start during busy: ignored, no effect on the latched config.
- ofifo_valid dropping in any state other than WAIT: ignored. The pop has already been issued, and ofifo_rd is never issued unless ofifo_valid=1 was seen in WAIT.
- Outside LATCH (acc_mode) and WRITE, sram_cen=1 and sram_addr/sram_d hold their last values.

Optional Feature:
- Macro: ODRAIN_SAT_EN.
- Defined: the RDACC add saturates per lane to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- Undefined: the add wraps modulo 2^psum_bw.
- ReLU applies after saturation or wrap in both builds.

Test Plan:
- Overwrite drain: num_out=4, base_addr=0x010, acc_mode=0, ofifo_valid held 1, lanes = index*10 -> writes at 0x010..0x013 with matching data. 4 ofifo_rd pulses. done 16 cycles after start.
- Accumulate drain: SRAM[0x020] lane0=100, OFIFO lane0=-30, acc_mode=1 -> read issued in LATCH, then write lane0=70 at 0x020 two cycles later. 5 cycles per vector.
- ReLU plus wrap: relu_en=1, lane = -5 in overwrite mode -> written 0. In accumulate mode, SRAM 0x7FFF + 1 -> 0 without ODRAIN_SAT_EN (wrapped 0x8000, clamped by ReLU), 0x7FFF with it.
- Stall and wrap: base_addr=0x7FE, num_out=4, ofifo_valid low for 10 cycles before vector 2 -> addresses 0x7FE, 0x7FF, 0x000, 0x001. No ofifo_rd while valid is low. busy stays high throughout.
- Reset mid-op: assert reset during RDACC -> all outputs at reset values immediately, no write. After release, start drains normally from cnt=0.
- start during busy: a second start pulse mid-drain -> ignored; exactly num_out writes with the original base_addr.
